// File: rtl/wb_stage_pkg.sv
// Shared MIPS writeback definitions: result sources, load types, queue entry layout.
package wb_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_COP0 = 2'd2,
    WB_SRC_LINK = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_type_e;

  typedef struct packed {
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Result/regFile/forwarding bundle between memory stage, wb_stage and decode.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic            i_valid;
  logic            o_ready;
  logic            i_reg_write;
  logic [1:0]      i_wb_src;
  logic [2:0]      i_ld_type;
  logic [1:0]      i_byte_off;
  logic [RAW-1:0]  i_wr_addr;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_mem_data;
  logic [XLEN-1:0] i_cop0_data;
  logic [XLEN-1:0] i_link_addr;
  logic            i_wr_hold;
  logic            i_flush;
  logic            o_rf_we;
  logic [RAW-1:0]  o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata;
  logic [RAW-1:0]  i_fwd_addr1;
  logic [RAW-1:0]  i_fwd_addr2;
  logic            o_fwd_hit1;
  logic            o_fwd_hit2;
  logic [XLEN-1:0] o_fwd_data1;
  logic [XLEN-1:0] o_fwd_data2;

  modport master (
    output i_valid, i_reg_write, i_wb_src, i_ld_type, i_byte_off, i_wr_addr,
           i_alu_result, i_mem_data, i_cop0_data, i_link_addr, i_wr_hold, i_flush,
           i_fwd_addr1, i_fwd_addr2,
    input  o_ready, o_rf_we, o_rf_waddr, o_rf_wdata,
           o_fwd_hit1, o_fwd_hit2, o_fwd_data1, o_fwd_data2
  );

  modport slave (
    input  i_valid, i_reg_write, i_wb_src, i_ld_type, i_byte_off, i_wr_addr,
           i_alu_result, i_mem_data, i_cop0_data, i_link_addr, i_wr_hold, i_flush,
           i_fwd_addr1, i_fwd_addr2,
    output o_ready, o_rf_we, o_rf_waddr, o_rf_wdata,
           o_fwd_hit1, o_fwd_hit2, o_fwd_data1, o_fwd_data2
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Big-endian load alignment: picks the half/byte from the raw word and extends it.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_ld_type,
  input  logic [1:0]      i_byte_off,
  output logic [XLEN-1:0] o_value_c
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Lane select then sign/zero extension by load type.
  always_comb begin
    w_half = i_byte_off[1] ? i_raw[15:0] : i_raw[31:16];
    case (i_byte_off)
      2'd0:    w_byte = i_raw[31:24];
      2'd1:    w_byte = i_raw[23:16];
      2'd2:    w_byte = i_raw[15:8];
      default: w_byte = i_raw[7:0];
    endcase
    case (i_ld_type)
      LD_LH:   o_value_c = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_value_c = {16'h0000, w_half};
      LD_LB:   o_value_c = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_value_c = {24'h000000, w_byte};
      default: o_value_c = i_raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: in-order result queue draining into the single regFile write port.
// Optional decode forwarding from pending entries when WB_FWD_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  wb_stage_if.slave  bus
);

  wb_entry_t       r_q [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_rf_we;
  logic [RAW-1:0]  r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_wdata;
  wb_entry_t       w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // $0 results are accepted but never queued; flush discards a same-cycle push.
  assign w_push  = bus.i_valid & ~w_full & bus.i_reg_write &
                   (bus.i_wr_addr != '0) & ~bus.i_flush;
  assign w_pop   = ~bus.i_wr_hold & ~w_empty & ~bus.i_flush;
  assign w_head  = r_q[r_rd_ptr];

  assign bus.o_ready    = ~w_full;
  assign bus.o_rf_we    = r_rf_we;
  assign bus.o_rf_waddr = r_rf_waddr;
  assign bus.o_rf_wdata = r_rf_wdata;

  wb_stage_load_align u_align (
    .i_raw      (bus.i_mem_data),
    .i_ld_type  (bus.i_ld_type),
    .i_byte_off (bus.i_byte_off),
    .o_value_c  (w_load)
  );

  // Write data source select; loads are aligned before they enter the queue.
  always_comb begin
    case (bus.i_wb_src)
      WB_SRC_MEM:  w_wdata = w_load;
      WB_SRC_COP0: w_wdata = bus.i_cop0_data;
      WB_SRC_LINK: w_wdata = bus.i_link_addr;
      default:     w_wdata = bus.i_alu_result;
    endcase
  end

  // Queue storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (w_push) begin
      r_q[r_wr_ptr] <= '{addr: bus.i_wr_addr, data: w_wdata};
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // regFile write register; address/data hold when nothing is written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head.addr;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  logic            w_hit1;
  logic            w_hit2;
  logic [XLEN-1:0] w_data1;
  logic [XLEN-1:0] w_data2;
  wb_entry_t       w_ent;

  // Output register is the oldest candidate; queue scanned oldest->newest so the youngest wins.
  always_comb begin
    w_ent   = '0;
    w_hit1  = r_rf_we & (r_rf_waddr == bus.i_fwd_addr1);
    w_hit2  = r_rf_we & (r_rf_waddr == bus.i_fwd_addr2);
    w_data1 = w_hit1 ? r_rf_wdata : '0;
    w_data2 = w_hit2 ? r_rf_wdata : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < r_count) begin
        w_ent = r_q[r_rd_ptr + AW'(k)];
        if (w_ent.addr == bus.i_fwd_addr1) begin
          w_hit1  = 1'b1;
          w_data1 = w_ent.data;
        end
        if (w_ent.addr == bus.i_fwd_addr2) begin
          w_hit2  = 1'b1;
          w_data2 = w_ent.data;
        end
      end
    end
    if (bus.i_fwd_addr1 == '0) begin
      w_hit1  = 1'b0;
      w_data1 = '0;
    end
    if (bus.i_fwd_addr2 == '0) begin
      w_hit2  = 1'b0;
      w_data2 = '0;
    end
  end

  assign bus.o_fwd_hit1  = w_hit1;
  assign bus.o_fwd_hit2  = w_hit2;
  assign bus.o_fwd_data1 = w_data1;
  assign bus.o_fwd_data2 = w_data2;
`else
  logic w_unused_fwd;

  assign w_unused_fwd    = ^{bus.i_fwd_addr1, bus.i_fwd_addr2};
  assign bus.o_fwd_hit1  = 1'b0;
  assign bus.o_fwd_hit2  = 1'b0;
  assign bus.o_fwd_data1 = '0;
  assign bus.o_fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-align vector table, directed corner cases,
// randomized traffic against a queue-based reference model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_if bus_if ();

  wb_stage #(.DEPTH(DEPTH), .AW(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  ld;
    logic [1:0]  off;
    logic [4:0]  addr;
    logic [31:0] alu, mem, cop0, link;
    logic [31:0] exp;
  } vec_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          n_checks = 0;
  int          n_pass   = 0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_value(input logic [1:0] src, input logic [2:0] ld,
      input logic [1:0] off, input logic [31:0] alu, input logic [31:0] mem,
      input logic [31:0] cop0, input logic [31:0] link);
    logic [31:0] b, h;
    if (src == 2'd0) return alu;
    if (src == 2'd2) return cop0;
    if (src == 2'd3) return link;
    b = (mem >> (8 * (3 - int'(off)))) & 32'hFF;
    h = (mem >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
    case (ld)
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      default: return mem;
    endcase
  endfunction

  task automatic model_fwd(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = 32'h0;
    if (FWD && addr != 5'd0) begin
      for (int i = q.size() - 1; i >= 0 && !hit; i--)
        if (q[i].a == addr) begin hit = 1'b1; data = q[i].d; end
      if (!hit && m_we && m_waddr == addr) begin hit = 1'b1; data = m_wdata; end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'h0;
  endtask

  task automatic set_idle();
    bus_if.i_valid = 1'b0; bus_if.i_reg_write = 1'b1; bus_if.i_wb_src = WB_SRC_ALU;
    bus_if.i_ld_type = LD_LW; bus_if.i_byte_off = 2'd0; bus_if.i_wr_addr = 5'd0;
    bus_if.i_alu_result = 32'h0; bus_if.i_mem_data = 32'h0; bus_if.i_cop0_data = 32'h0;
    bus_if.i_link_addr = 32'h0; bus_if.i_wr_hold = 1'b0; bus_if.i_flush = 1'b0;
  endtask

  task automatic set_push(input logic [1:0] src, input logic [2:0] ld, input logic [1:0] off,
      input logic [4:0] addr, input logic [31:0] alu, input logic [31:0] mem,
      input logic [31:0] cop0, input logic [31:0] link);
    bus_if.i_valid = 1'b1; bus_if.i_reg_write = 1'b1; bus_if.i_wb_src = src;
    bus_if.i_ld_type = ld; bus_if.i_byte_off = off; bus_if.i_wr_addr = addr;
    bus_if.i_alu_result = alu; bus_if.i_mem_data = mem; bus_if.i_cop0_data = cop0;
    bus_if.i_link_addr = link;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic        e_hit, rdy, push;
    logic [31:0] e_data;
    ent_t        e;
    #3;
    rdy = (q.size() < DEPTH);
    check("o_ready", bus_if.o_ready, rdy);
    model_fwd(bus_if.i_fwd_addr1, e_hit, e_data);
    check("fwd_hit1", bus_if.o_fwd_hit1, e_hit);
    if (e_hit || !FWD) check("fwd_data1", bus_if.o_fwd_data1, e_data);
    model_fwd(bus_if.i_fwd_addr2, e_hit, e_data);
    check("fwd_hit2", bus_if.o_fwd_hit2, e_hit);
    if (e_hit || !FWD) check("fwd_data2", bus_if.o_fwd_data2, e_data);
    push = bus_if.i_valid && rdy && bus_if.i_reg_write && (bus_if.i_wr_addr != 5'd0);
    e.a = bus_if.i_wr_addr;
    e.d = ref_value(bus_if.i_wb_src, bus_if.i_ld_type, bus_if.i_byte_off, bus_if.i_alu_result,
                    bus_if.i_mem_data, bus_if.i_cop0_data, bus_if.i_link_addr);
    @(posedge clk);
    if (bus_if.i_flush) begin
      q.delete();
      m_we = 1'b0;
    end else begin
      if (!bus_if.i_wr_hold && q.size() > 0) begin
        m_we = 1'b1; m_waddr = q[0].a; m_wdata = q[0].d;
        void'(q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (push) q.push_back(e);
    end
    #1;
    check("rf_we", bus_if.o_rf_we, m_we);
    check("rf_waddr", bus_if.o_rf_waddr, m_waddr);
    check("rf_wdata", bus_if.o_rf_wdata, m_wdata);
  endtask

  initial begin
    vecs[0]  = '{WB_SRC_ALU,  LD_LW,  2'd0, 5'd5,  32'h1234_5678, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 32'h1234_5678};
    vecs[1]  = '{WB_SRC_MEM,  LD_LB,  2'd1, 5'd6,  32'h0BAD_0000, 32'h0080_0000, 32'h0BAD_0002, 32'h0BAD_0003, 32'hFFFF_FF80};
    vecs[2]  = '{WB_SRC_MEM,  LD_LBU, 2'd1, 5'd7,  32'h0BAD_0000, 32'h0080_0000, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0000_0080};
    vecs[3]  = '{WB_SRC_MEM,  LD_LHU, 2'd2, 5'd8,  32'h0BAD_0000, 32'hAAAA_BEEF, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0000_BEEF};
    vecs[4]  = '{WB_SRC_MEM,  LD_LH,  2'd0, 5'd9,  32'h0BAD_0000, 32'hAAAA_BEEF, 32'h0BAD_0002, 32'h0BAD_0003, 32'hFFFF_AAAA};
    vecs[5]  = '{WB_SRC_MEM,  LD_LH,  2'd2, 5'd10, 32'h0BAD_0000, 32'h1234_7FFF, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0000_7FFF};
    vecs[6]  = '{WB_SRC_MEM,  LD_LB,  2'd3, 5'd11, 32'h0BAD_0000, 32'h0000_00FF, 32'h0BAD_0002, 32'h0BAD_0003, 32'hFFFF_FFFF};
    vecs[7]  = '{WB_SRC_MEM,  LD_LBU, 2'd0, 5'd12, 32'h0BAD_0000, 32'hC300_0000, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0000_00C3};
    vecs[8]  = '{WB_SRC_MEM,  LD_LB,  2'd2, 5'd13, 32'h0BAD_0000, 32'h0000_7F00, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0000_007F};
    vecs[9]  = '{WB_SRC_MEM,  LD_LW,  2'd0, 5'd14, 32'h0BAD_0000, 32'hDEAD_BEEF, 32'h0BAD_0002, 32'h0BAD_0003, 32'hDEAD_BEEF};
    vecs[10] = '{WB_SRC_COP0, LD_LW,  2'd0, 5'd15, 32'h0BAD_0000, 32'h0BAD_0001, 32'hCAFE_F00D, 32'h0BAD_0003, 32'hCAFE_F00D};
    vecs[11] = '{WB_SRC_LINK, LD_LW,  2'd0, 5'd31, 32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0040_0108, 32'h0040_0108};

    // Reset values.
    rst_n = 1'b0;
    set_idle();
    bus_if.i_fwd_addr1 = 5'd5; bus_if.i_fwd_addr2 = 5'd7;
    model_reset();
    #12;
    check("rst_ready", bus_if.o_ready, 1'b1);
    check("rst_we", bus_if.o_rf_we, 1'b0);
    check("rst_waddr", bus_if.o_rf_waddr, 5'd0);
    check("rst_wdata", bus_if.o_rf_wdata, 32'h0);
    check("rst_hit1", bus_if.o_fwd_hit1, 1'b0);
    check("rst_hit2", bus_if.o_fwd_hit2, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Source select and load alignment table: push, then one-cycle-later write.
    foreach (vecs[i]) begin
      set_push(vecs[i].src, vecs[i].ld, vecs[i].off, vecs[i].addr,
               vecs[i].alu, vecs[i].mem, vecs[i].cop0, vecs[i].link);
      step();
      set_idle();
      step();
      check($sformatf("vec%0d_we", i), bus_if.o_rf_we, 1'b1);
      check($sformatf("vec%0d_waddr", i), bus_if.o_rf_waddr, vecs[i].addr);
      check($sformatf("vec%0d_wdata", i), bus_if.o_rf_wdata, vecs[i].exp);
    end
    step();

    // Fill under hold, 5th producer held off, then in-order drain one per cycle.
    bus_if.i_wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'(i), 32'h100 + 32'(i), 32'h0, 32'h0, 32'h0);
      step();
    end
    check("t3_full_ready", bus_if.o_ready, 1'b0);
    set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'd9, 32'h999, 32'h0, 32'h0, 32'h0);
    step();
    step();
    check("t3_held_ready", bus_if.o_ready, 1'b0);
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("t3_drain%0d_we", i), bus_if.o_rf_we, 1'b1);
      check($sformatf("t3_drain%0d_waddr", i), bus_if.o_rf_waddr, 5'(i));
      check($sformatf("t3_drain%0d_wdata", i), bus_if.o_rf_wdata, 32'h100 + 32'(i));
    end
    step();
    check("t3_after_we", bus_if.o_rf_we, 1'b0);

    // $0 dropped; youngest of two pending writes to $7 forwards.
    set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'd0, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0);
    step();
    set_idle();
    step();
    check("t4_r0_we", bus_if.o_rf_we, 1'b0);
    step();
    check("t4_r0_we2", bus_if.o_rf_we, 1'b0);
    bus_if.i_wr_hold = 1'b1;
    set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'd7, 32'd1, 32'h0, 32'h0, 32'h0);
    step();
    set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'd7, 32'd2, 32'h0, 32'h0, 32'h0);
    step();
    set_idle();
    bus_if.i_wr_hold = 1'b1;
    bus_if.i_fwd_addr1 = 5'd7; bus_if.i_fwd_addr2 = 5'd0;
    #2;
    check("t4_fwd_hit1", bus_if.o_fwd_hit1, FWD);
    check("t4_fwd_data1", bus_if.o_fwd_data1, FWD ? 32'd2 : 32'd0);
    check("t4_fwd_hit2_r0", bus_if.o_fwd_hit2, 1'b0);
    step();
    bus_if.i_wr_hold = 1'b0;
    step();
    step();
    #2;
    check("t4_fwd_outreg_hit1", bus_if.o_fwd_hit1, FWD);
    check("t4_fwd_outreg_data1", bus_if.o_fwd_data1, FWD ? 32'd2 : 32'd0);
    step();
    step();

    // Flush of three entries, with a same-cycle push that must be discarded.
    bus_if.i_wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'(20 + i), 32'hA0 + 32'(i), 32'h0, 32'h0, 32'h0);
      step();
    end
    bus_if.i_fwd_addr1 = 5'd20; bus_if.i_fwd_addr2 = 5'd23;
    set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'd23, 32'hA3, 32'h0, 32'h0, 32'h0);
    bus_if.i_flush = 1'b1;
    step();
    set_idle();
    #2;
    check("t5_ready", bus_if.o_ready, 1'b1);
    check("t5_we", bus_if.o_rf_we, 1'b0);
    check("t5_hit1", bus_if.o_fwd_hit1, 1'b0);
    check("t5_hit2", bus_if.o_fwd_hit2, 1'b0);
    step();
    check("t5_we_after", bus_if.o_rf_we, 1'b0);

    // Asynchronous reset in the middle of a drain.
    bus_if.i_wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(WB_SRC_ALU, LD_LW, 2'd0, 5'(24 + i), 32'hB0 + 32'(i), 32'h0, 32'h0, 32'h0);
      step();
    end
    set_idle();
    step();
    check("t6_drain_we", bus_if.o_rf_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_we", bus_if.o_rf_we, 1'b0);
    check("t6_rst_waddr", bus_if.o_rf_waddr, 5'd0);
    check("t6_rst_wdata", bus_if.o_rf_wdata, 32'h0);
    check("t6_rst_ready", bus_if.o_ready, 1'b1);
    @(posedge clk); #1;
    check("t6_inrst_we", bus_if.o_rf_we, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_post_we", bus_if.o_rf_we, 1'b0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      set_push(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
      bus_if.i_valid     = ($urandom_range(0, 99) < 60);
      bus_if.i_reg_write = ($urandom_range(0, 99) < 85);
      bus_if.i_wr_hold   = ($urandom_range(0, 99) < 35);
      bus_if.i_flush     = ($urandom_range(0, 99) < 4);
      bus_if.i_fwd_addr1 = 5'($urandom_range(0, 7));
      bus_if.i_fwd_addr2 = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
